ddr2_cmd_arbiter: RTL

- Owns the DDR2 command bus (cke/cmd/ba/addr) after power-up.
- During initialization, passes the init sequencer's commands through to the pins.
- After `init_end`, runs a periodic auto-refresh scheduler and shares the bus between one write engine and one read engine.
- Arbitration priority: refresh first, then write and read alternating.

---
 rtl/ddr2_pkg.sv | 34 +++
 rtl/ddr2_ref_timer.sv | 58 +++++
 rtl/ddr2_cmd_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ddr2_pkg.sv
// Shared DDR2 command encodings, timing conversions and arbiter state type.
package ddr2_pkg;

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdLm   = 4'b0000;

  // Round up so a timing constraint is never shortened by truncation.
  function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned tck);
    return (ns + tck - 1) / tck;
  endfunction

  localparam int unsigned T_CK_NS   = 5;
  localparam int unsigned T_REFI_NS = 7800;
  localparam int unsigned T_RP_NS   = 20;
  localparam int unsigned T_RFC_NS  = 130;

  localparam int unsigned REFI_CYC = ns_to_cyc(T_REFI_NS, T_CK_NS);
  localparam int unsigned TRP_CYC  = ns_to_cyc(T_RP_NS, T_CK_NS);
  localparam int unsigned TRFC_CYC = ns_to_cyc(T_RFC_NS, T_CK_NS);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRefPre,
    StRefTrp,
    StRefAref,
    StRefTrfc,
    StWrite,
    StRead
  } arb_state_e;

endpackage

// File: rtl/ddr2_ref_timer.sv
// Periodic auto-refresh request generator with sticky overrun flag.
module ddr2_ref_timer
  import ddr2_pkg::*;
#(
  parameter int unsigned RefiCyc = REFI_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ref_ack,
  output logic ref_req,
  output logic ref_overrun
);

  localparam int unsigned CntW = $clog2(RefiCyc);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            ovr_q, ovr_d;
  logic            term;

  assign term = enable && (cnt_q == CntW'(RefiCyc - 1));

  always_comb begin
    cnt_d = cnt_q;
    req_d = req_q;
    ovr_d = ovr_q;
    if (enable) begin
      cnt_d = term ? '0 : cnt_q + CntW'(1);
    end
    if (ref_ack) begin
      req_d = 1'b0;
    end
    // A new expiry wins over a same-cycle ack so no interval is lost.
    if (term) begin
      req_d = 1'b1;
      if (req_q) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      req_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
      ovr_q <= ovr_d;
    end
  end

  assign ref_req     = req_q;
  assign ref_overrun = ovr_q;

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command bus owner: init passthrough, then refresh/write/read arbitration
// onto registered pins.
module ddr2_cmd_arbiter
  import ddr2_pkg::*;
#(
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned tCK       = 5,
  parameter int unsigned tREFI     = 7800,
  parameter int unsigned tRP       = 20,
  parameter int unsigned tRFC      = 130
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_end,
  input  logic                 init_cke,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 wr_req,
  input  logic                 wr_end,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_en,
  input  logic                 rd_req,
  input  logic                 rd_end,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_en,
  output logic                 ddr2_cke,
  output logic [3:0]           ddr2_cmd,
  output logic [BA_BITS-1:0]   ddr2_ba,
  output logic [ADDR_BITS-1:0] ddr2_addr,
  output logic                 ref_overrun
);

  localparam int unsigned RefiCyc = ns_to_cyc(tREFI, tCK);
  localparam int unsigned TrpCyc  = ns_to_cyc(tRP, tCK);
  localparam int unsigned TrfcCyc = ns_to_cyc(tRFC, tCK);
  localparam int unsigned WaitW   = $clog2(TrfcCyc);

  arb_state_e           state_q, state_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 last_wr_q, last_wr_d;
  logic                 cke_q, cke_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 ref_req;
  logic                 ref_ack;

  ddr2_ref_timer #(
    .RefiCyc (RefiCyc)
  ) u_ref_timer (
    .clk         (clk),
    .rst         (rst),
    .enable      (init_end),
    .ref_ack     (ref_ack),
    .ref_req     (ref_req),
    .ref_overrun (ref_overrun)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    last_wr_d = last_wr_q;
    ref_ack   = 1'b0;
    cke_d     = 1'b1;
    cmd_d     = CmdNop;
    ba_d      = '0;
    addr_d    = '0;

    unique case (state_q)
      StInit: begin
        cke_d  = init_cke;
        cmd_d  = init_cmd;
        ba_d   = init_ba;
        addr_d = init_addr;
        if (init_end) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (ref_req) begin
          state_d = StRefPre;
        end else if (wr_req && rd_req) begin
          state_d = last_wr_q ? StRead : StWrite;
        end else if (wr_req) begin
          state_d = StWrite;
        end else if (rd_req) begin
          state_d = StRead;
        end
      end
      StRefPre: begin
        cmd_d      = CmdPre;
        addr_d[10] = 1'b1;
        wait_d     = '0;
        state_d    = StRefTrp;
      end
      StRefTrp: begin
        if (wait_q == WaitW'(TrpCyc - 2)) begin
          state_d = StRefAref;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRefAref: begin
        cmd_d   = CmdAref;
        ref_ack = 1'b1;
        wait_d  = '0;
        state_d = StRefTrfc;
      end
      StRefTrfc: begin
        if (wait_q == WaitW'(TrfcCyc - 2)) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWrite: begin
        cmd_d  = wr_cmd;
        ba_d   = wr_ba;
        addr_d = wr_addr;
        if (wr_end) begin
          state_d   = StIdle;
          last_wr_d = 1'b1;
        end
      end
      StRead: begin
        cmd_d  = rd_cmd;
        ba_d   = rd_ba;
        addr_d = rd_addr;
        if (rd_end) begin
          state_d   = StIdle;
          last_wr_d = 1'b0;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      wait_q    <= '0;
      last_wr_q <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= CmdNop;
      ba_q      <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      last_wr_q <= last_wr_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
    end
  end

  assign wr_en     = (state_q == StWrite);
  assign rd_en     = (state_q == StRead);
  assign ddr2_cke  = cke_q;
  assign ddr2_cmd  = cmd_q;
  assign ddr2_ba   = ba_q;
  assign ddr2_addr = addr_q;

endmodule
